icache: RTL and testbench

- Direct-mapped instruction cache; the responder side of the fetcher's fetch request/return handshake.
- Returns a hit combinationally in the same cycle as the request.
- On a miss, it issues one 32-bit word read to the memory controller, fills the line, and then serves the held request as a hit.
- Sits between the instruction fetcher and the memory-controller arbiter.

---
 rtl/icache.sv | 144 ++++++++++++++
 tb/tb_icache.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache: direct-mapped instruction cache, one 32-bit word per line.
//
// Purpose:
//   Answers instruction fetch requests. A hit is returned combinationally in
//   the request cycle. A miss issues a single word read to the memory
//   controller. The returned word is written into the line. The held request
//   is then served from the hit path in the first IDLE cycle after the fill.
//
// Handshake (valid/ready):
//   The fetcher raises rdy_to_fetch with a stable, word-aligned pc_2icache
//   and holds both until it sees instr_valid. A response is consumed on the
//   clock edge where instr_valid is high and is never held across cycles.
//   Toward memory, mem_req/mem_addr are held stable until the one-cycle
//   mem_valid pulse. An issued read is never aborted. rdy=0 freezes
//   everything and suppresses instr_valid.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rdy                global ready (0 = pause)
//   rdy_to_fetch       fetch request from the fetcher
//   pc_2icache         fetch address
//   instr_valid        instruction returned this cycle
//   instr_from_icache  instruction word (0 when not a hit)
//   mem_req, mem_addr  registered word-read request to memory
//   mem_valid, mem_data  read response from memory
//   dbg_state          current FSM state (0 = IDLE, 1 = WAIT)
// ---------------------------------------------------------------------------
module icache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rdy_to_fetch,
  input  logic [31:0] pc_2icache,
  output logic        instr_valid,
  output logic [31:0] instr_from_icache,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic        dbg_state
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [31:0]           r_data [LINES];

  logic [31:0]           r_miss_addr;
  logic                  r_mem_req;

  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_miss_index;
  logic [TAG_BITS-1:0]   w_miss_tag;
  logic                  w_hit;
  logic                  w_start_miss;
  logic                  w_fill;

  assign w_index      = pc_2icache[INDEX_BITS+1:2];
  assign w_tag        = pc_2icache[31:INDEX_BITS+2];
  assign w_miss_index = r_miss_addr[INDEX_BITS+1:2];
  assign w_miss_tag   = r_miss_addr[31:INDEX_BITS+2];

  assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // Next-state and handshake decode. Fills only complete while rdy=1, so a
  // stray mem_valid during a pause (or in IDLE) is ignored.
  always_comb begin
    w_next_state      = r_state;
    w_start_miss      = 1'b0;
    w_fill            = 1'b0;
    instr_valid       = 1'b0;
    instr_from_icache = 32'h0;
    if (w_hit) begin
      instr_from_icache = r_data[w_index];
    end
    case (r_state)
      S_IDLE: begin
        if (rdy && rdy_to_fetch) begin
          if (w_hit) begin
            instr_valid = 1'b1;
          end else begin
            w_start_miss = 1'b1;
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (rdy && mem_valid) begin
          w_fill       = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_mem_req   <= 1'b0;
      r_miss_addr <= 32'h0;
    end else if (rdy) begin
      r_state <= w_next_state;
      if (w_start_miss) begin
        r_miss_addr <= {pc_2icache[31:2], 2'b00};
        r_mem_req   <= 1'b1;
      end
      if (w_fill) begin
        r_valid[w_miss_index] <= 1'b1;
        r_mem_req             <= 1'b0;
      end
    end
  end

  // Tag and data storage carry no reset; the valid bits alone gate hits.
  // w_fill already implies rdy=1.
  always_ff @(posedge clk) begin
    if (w_fill && !rst) begin
      r_tag[w_miss_index]  <= w_miss_tag;
      r_data[w_miss_index] <= mem_data;
    end
  end

  // The read address is the latched miss address itself.
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_miss_addr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache: directed self-checking bench for icache (INDEX_BITS = 8).
// Inputs change on the falling edge; outputs are checked 1 time unit later,
// well away from the rising (active) edge.
// ---------------------------------------------------------------------------
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rdy_to_fetch;
  logic [31:0] pc_2icache;
  logic        instr_valid;
  logic [31:0] instr_from_icache;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  icache #(.INDEX_BITS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .rdy_to_fetch      (rdy_to_fetch),
    .pc_2icache        (pc_2icache),
    .instr_valid       (instr_valid),
    .instr_from_icache (instr_from_icache),
    .mem_req           (mem_req),
    .mem_addr          (mem_addr),
    .mem_valid         (mem_valid),
    .mem_data          (mem_data),
    .dbg_state         (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Miss with a one-cycle memory response, then a hit on the held request.
  // Called at a falling edge; leaves rdy_to_fetch low at a falling edge.
  task automatic fetch_miss(input string tag, input logic [31:0] pc, input logic [31:0] data);
    rdy_to_fetch = 1'b1;
    pc_2icache   = pc;
    settle();
    chk({tag, "_miss_iv"}, {31'b0, instr_valid}, 32'h0);
    step();
    settle();
    chk({tag, "_req"},  {31'b0, mem_req}, 32'h1);
    chk({tag, "_addr"}, mem_addr, {pc[31:2], 2'b00});
    mem_valid = 1'b1;
    mem_data  = data;
    step();
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    settle();
    chk({tag, "_fill_iv"},    {31'b0, instr_valid}, 32'h1);
    chk({tag, "_fill_instr"}, instr_from_icache, data);
    chk({tag, "_fill_req"},   {31'b0, mem_req}, 32'h0);
    step();
    rdy_to_fetch = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    rdy          = 1'b1;
    rdy_to_fetch = 1'b0;
    pc_2icache   = 32'h0;
    mem_valid    = 1'b0;
    mem_data     = 32'h0;
    step();
    step();
    settle();
    // reset state
    chk("rst_req",   {31'b0, mem_req}, 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    chk("rst_state", {31'b0, dbg_state}, 32'h0);
    chk("rst_iv",    {31'b0, instr_valid}, 32'h0);

    // cold miss, memory answers in the 3rd request cycle
    step();
    rst          = 1'b0;
    rdy_to_fetch = 1'b1;
    pc_2icache   = 32'h0;
    settle();
    chk("cold_c0_iv",  {31'b0, instr_valid}, 32'h0);
    chk("cold_c0_req", {31'b0, mem_req}, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 3) begin
        mem_valid = 1'b1;
        mem_data  = 32'h0000_0013;
      end
      settle();
      chk("cold_req",   {31'b0, mem_req}, 32'h1);
      chk("cold_addr",  mem_addr, 32'h0);
      chk("cold_iv",    {31'b0, instr_valid}, 32'h0);
      chk("cold_state", {31'b0, dbg_state}, 32'h1);
    end
    chk("cold_no_fwd", instr_from_icache, 32'h0);
    step();
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    settle();
    chk("cold_c4_iv",    {31'b0, instr_valid}, 32'h1);
    chk("cold_c4_instr", instr_from_icache, 32'h0000_0013);
    chk("cold_c4_req",   {31'b0, mem_req}, 32'h0);
    step();
    rdy_to_fetch = 1'b0;

    // hit
    step();
    rdy_to_fetch = 1'b1;
    pc_2icache   = 32'h0;
    settle();
    chk("hit_iv",    {31'b0, instr_valid}, 32'h1);
    chk("hit_instr", instr_from_icache, 32'h0000_0013);
    step();
    rdy_to_fetch = 1'b0;
    settle();
    chk("hit_req", {31'b0, mem_req}, 32'h0);

    // conflict eviction on index 1
    fetch_miss("ev_a", 32'h0000_0004, 32'hAAAA_0004);
    fetch_miss("ev_b", 32'h0000_0404, 32'hBBBB_0404);
    fetch_miss("ev_c", 32'h0000_0004, 32'hCCCC_0004);

    // rollback during WAIT
    rdy_to_fetch = 1'b1;
    pc_2icache   = 32'h0000_0100;
    settle();
    chk("rb_miss_iv", {31'b0, instr_valid}, 32'h0);
    step();
    rdy_to_fetch = 1'b0;
    pc_2icache   = 32'h0000_0200;
    settle();
    chk("rb_req1",  {31'b0, mem_req}, 32'h1);
    chk("rb_addr1", mem_addr, 32'h0000_0100);
    step();
    rdy_to_fetch = 1'b1;
    mem_valid    = 1'b1;
    mem_data     = 32'h1111_0100;
    settle();
    chk("rb_addr2",   mem_addr, 32'h0000_0100);
    chk("rb_wait_iv", {31'b0, instr_valid}, 32'h0);
    step();
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    settle();
    chk("rb_200_miss_iv", {31'b0, instr_valid}, 32'h0);
    chk("rb_idle_req",    {31'b0, mem_req}, 32'h0);
    step();
    settle();
    chk("rb_200_req",  {31'b0, mem_req}, 32'h1);
    chk("rb_200_addr", mem_addr, 32'h0000_0200);
    mem_valid = 1'b1;
    mem_data  = 32'h2222_0200;
    step();
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    settle();
    chk("rb_200_iv",    {31'b0, instr_valid}, 32'h1);
    chk("rb_200_instr", instr_from_icache, 32'h2222_0200);
    step();
    pc_2icache = 32'h0000_0100;
    settle();
    chk("rb_100_hit_iv",    {31'b0, instr_valid}, 32'h1);
    chk("rb_100_hit_instr", instr_from_icache, 32'h1111_0100);
    step();
    rdy_to_fetch = 1'b0;

    // pause mid-WAIT, with a stray mem_valid that must be ignored
    rdy_to_fetch = 1'b1;
    pc_2icache   = 32'h0000_0300;
    step();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = (i == 1);
      mem_data  = (i == 1) ? 32'hDEAD_BEEF : 32'h0;
      settle();
      chk("pw_req",   {31'b0, mem_req}, 32'h1);
      chk("pw_addr",  mem_addr, 32'h0000_0300);
      chk("pw_iv",    {31'b0, instr_valid}, 32'h0);
      chk("pw_state", {31'b0, dbg_state}, 32'h1);
      step();
    end
    rdy       = 1'b1;
    mem_valid = 1'b1;
    mem_data  = 32'h3333_0300;
    settle();
    chk("pw_resume_req", {31'b0, mem_req}, 32'h1);
    step();
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    settle();
    chk("pw_iv_after",    {31'b0, instr_valid}, 32'h1);
    chk("pw_instr_after", instr_from_icache, 32'h3333_0300);
    step();
    rdy_to_fetch = 1'b0;

    // pause mid-hit
    rdy_to_fetch = 1'b1;
    pc_2icache   = 32'h0;
    rdy          = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("ph_iv",    {31'b0, instr_valid}, 32'h0);
      chk("ph_req",   {31'b0, mem_req}, 32'h0);
      chk("ph_instr", instr_from_icache, 32'h0000_0013);
      step();
    end
    rdy = 1'b1;
    settle();
    chk("ph_resume_iv", {31'b0, instr_valid}, 32'h1);
    step();
    rdy_to_fetch = 1'b0;

    // reset mid-WAIT, then a late mem_valid in IDLE
    rdy_to_fetch = 1'b1;
    pc_2icache   = 32'h0000_0500;
    step();
    settle();
    chk("rw_req", {31'b0, mem_req}, 32'h1);
    rst          = 1'b1;
    rdy_to_fetch = 1'b0;
    step();
    rst = 1'b0;
    settle();
    chk("rw_req_after",   {31'b0, mem_req}, 32'h0);
    chk("rw_state_after", {31'b0, dbg_state}, 32'h0);
    mem_valid = 1'b1;
    mem_data  = 32'h5555_0500;
    step();
    mem_valid = 1'b0;
    mem_data  = 32'h0;
    settle();
    chk("rw_late_req", {31'b0, mem_req}, 32'h0);
    fetch_miss("rw_line0", 32'h0, 32'h0000_0093);
    fetch_miss("rw_500",   32'h0000_0500, 32'h6666_0500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
